// File: rtl/pipelined_mac.sv
// Multiply-accumulate with a STAGES-deep valid pipeline and ready/valid handshaking.
// The product is formed on entry, then carried through STAGES-1 registers and accumulated in the output stage.
module pipelined_mac #(
    parameter int A_W    = 16,
    parameter int B_W    = 16,
    parameter int STAGES = 3,
    parameter int ACC_W  = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   A,
    input  logic [B_W-1:0]   B,
    input  logic             is_signed,
    input  logic             acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] C,
    output logic             ovf
);

    localparam int PW = A_W + B_W + 2;

    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("pipelined_mac: STAGES must be in 1..8");
    end
    if (ACC_W < A_W + B_W) begin : g_bad_acc_w
        $error("pipelined_mac: ACC_W must be at least A_W+B_W");
    end

    logic             advance;
    logic             out_valid_q;
    logic [ACC_W-1:0] c_q;
    logic [ACC_W-1:0] c_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [ACC_W:0]   sum;

    logic             last_valid;
    logic             last_signed;
    logic             last_acc;
    logic [ACC_W-1:0] last_prod;

    // The whole pipeline moves as one; a full output stage that is not being drained freezes everything.
    assign advance  = out_ready | ~out_valid_q;
    assign in_ready = advance;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic             stg_valid;
            logic             stg_signed;
            logic             stg_acc;
            logic [ACC_W-1:0] stg_prod;

            if (gi == 0) begin : g_mul
                logic signed [A_W:0]  a_ext;
                logic signed [B_W:0]  b_ext;
                logic signed [PW-1:0] p_full;

                // One extra bit per operand lets a single signed multiplier serve both modes.
                assign a_ext      = {is_signed & A[A_W-1], A};
                assign b_ext      = {is_signed & B[B_W-1], B};
                assign p_full     = PW'(a_ext) * PW'(b_ext);
                assign stg_prod   = ACC_W'(p_full);
                assign stg_valid  = in_valid & advance;
                assign stg_signed = is_signed;
                assign stg_acc    = acc;
            end else begin : g_reg
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        stg_valid  <= 1'b0;
                        stg_signed <= 1'b0;
                        stg_acc    <= 1'b0;
                        stg_prod   <= '0;
                    end else if (advance) begin
                        stg_valid <= g_stage[gi-1].stg_valid;
                        if (g_stage[gi-1].stg_valid) begin
                            stg_signed <= g_stage[gi-1].stg_signed;
                            stg_acc    <= g_stage[gi-1].stg_acc;
                            stg_prod   <= g_stage[gi-1].stg_prod;
                        end
                    end
                end
            end
        end
    endgenerate

    assign last_valid  = g_stage[STAGES-1].stg_valid;
    assign last_signed = g_stage[STAGES-1].stg_signed;
    assign last_acc    = g_stage[STAGES-1].stg_acc;
    assign last_prod   = g_stage[STAGES-1].stg_prod;

    always_comb begin
        sum   = {1'b0, c_q} + {1'b0, last_prod};
        c_d   = last_prod;
        ovf_d = 1'b0;
        if (last_acc) begin
            c_d = sum[ACC_W-1:0];
            // Signed overflow: like-signed operands yielding a differently signed result.
            if (last_signed) begin
                ovf_d = (c_q[ACC_W-1] == last_prod[ACC_W-1]) &&
                        (sum[ACC_W-1] != c_q[ACC_W-1]);
            end else begin
                ovf_d = sum[ACC_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            c_q         <= '0;
            ovf_q       <= 1'b0;
        end else if (advance) begin
            out_valid_q <= last_valid;
            if (last_valid) begin
                c_q   <= c_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign C         = c_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_mac.sv
// Scoreboard bench for pipelined_mac: a default 40-bit instance and a 32-bit instance for wrap/overflow cases.
module tb_pipelined_mac;

    localparam int STAGES = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, is_signed, acc, out_valid, out_ready, ovf;
    logic [15:0] A, B;
    logic [39:0] C;

    logic        in_valid2, in_ready2, is_signed2, acc2, out_valid2, out_ready2, ovf2;
    logic [15:0] A2, B2;
    logic [31:0] C2;

    pipelined_mac dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .is_signed(is_signed), .acc(acc),
        .out_valid(out_valid), .out_ready(out_ready), .C(C), .ovf(ovf)
    );

    pipelined_mac #(.ACC_W(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .A(A2), .B(B2), .is_signed(is_signed2), .acc(acc2),
        .out_valid(out_valid2), .out_ready(out_ready2), .C(C2), .ovf(ovf2)
    );

    typedef struct {
        logic [39:0] c;
        logic        o;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors sample 3 time units after the falling edge, when all bench drives have settled.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            #3;
            if (rst && out_valid) begin
                if (q0.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got C=%0h with no beat outstanding", C);
                end else begin
                    e = q0[0];
                    check("C", C, e.c);
                    check("ovf", 40'(ovf), 40'(e.o));
                    if (out_ready) begin
                        if (e.lat) check("latency", 40'(cyc - e.cyc), 40'(STAGES));
                        $display("out40: C=%0h ovf=%0b", C, ovf);
                        void'(q0.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            #3;
            if (rst && out_valid2) begin
                if (q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out32: got C=%0h with no beat outstanding", C2);
                end else begin
                    e = q1[0];
                    check("C32", {8'h00, C2}, e.c);
                    check("ovf32", 40'(ovf2), 40'(e.o));
                    if (out_ready2) begin
                        if (e.lat) check("latency32", 40'(cyc - e.cyc), 40'(STAGES));
                        $display("out32: C=%0h ovf=%0b", C2, ovf2);
                        void'(q1.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input int t, input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic ac, input logic [39:0] ec, input logic eo, input bit lat);
        int   w = 0;
        exp_t e;
        @(negedge clk);
        if (t == 0) begin
            A = a; B = b; is_signed = s; acc = ac; in_valid = 1'b1;
        end else begin
            A2 = a; B2 = b; is_signed2 = s; acc2 = ac; in_valid2 = 1'b1;
        end
        #1;
        while (!(t == 0 ? in_ready : in_ready2) && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!(t == 0 ? in_ready : in_ready2)) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end else begin
            e.c = ec; e.o = eo; e.cyc = cyc; e.lat = lat;
            if (t == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((q0.size() != 0 || q1.size() != 0) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d/%0d outstanding expected 0", q0.size(), q1.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; A = '0; B = '0; is_signed = 1'b0; acc = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; A2 = '0; B2 = '0; is_signed2 = 1'b0; acc2 = 1'b0; out_ready2 = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_out_valid", 40'(out_valid), 40'(0));
        check("rst_C", C, 40'(0));
        check("rst_ovf", 40'(ovf), 40'(0));
        check("rst_in_ready", 40'(in_ready), 40'(1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check("rel_in_ready", 40'(in_ready), 40'(1));
        @(posedge clk);
        #1;
        check("first_edge_in_ready", 40'(in_ready), 40'(1));
        check("first_edge_out_valid", 40'(out_valid), 40'(0));

        // Single unsigned load
        send(0, 16'd25, 16'd15, 1'b0, 1'b0, 40'd375, 1'b0, 1'b1);
        idle(); drain();

        // Back-to-back throughput
        send(0, 16'd255, 16'd255, 1'b0, 1'b0, 40'd65025, 1'b0, 1'b1);
        send(0, 16'd1024, 16'd512, 1'b0, 1'b0, 40'd524288, 1'b0, 1'b1);
        idle(); drain();

        // Sign vs zero extension of the same operands
        send(0, 16'hFFFF, 16'd2, 1'b1, 1'b0, 40'hFFFFFFFFFE, 1'b0, 1'b1);
        send(0, 16'hFFFF, 16'd2, 1'b0, 1'b0, 40'h000001FFFE, 1'b0, 1'b1);
        idle(); drain();

        // Accumulation and per-mode overflow on the 40-bit instance
        send(0, 16'd3, 16'd4, 1'b0, 1'b0, 40'd12, 1'b0, 1'b1);
        send(0, 16'd5, 16'd6, 1'b0, 1'b1, 40'd42, 1'b0, 1'b1);
        send(0, 16'hFFFF, 16'd2, 1'b1, 1'b0, 40'hFFFFFFFFFE, 1'b0, 1'b1);
        send(0, 16'd1, 16'd2, 1'b0, 1'b1, 40'h0000000000, 1'b1, 1'b1);
        send(0, 16'd3, 16'hFFFF, 1'b1, 1'b1, 40'hFFFFFFFFFD, 1'b0, 1'b1);
        send(0, 16'd3, 16'hFFFF, 1'b1, 1'b1, 40'hFFFFFFFFFA, 1'b0, 1'b1);
        idle(); drain();

        // 32-bit accumulator wrap and signed overflow
        send(1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 40'hFFFE0001, 1'b0, 1'b1);
        send(1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 40'hFFFC0002, 1'b1, 1'b1);
        send(1, 16'h8000, 16'h8000, 1'b1, 1'b0, 40'h40000000, 1'b0, 1'b1);
        send(1, 16'h8000, 16'h8000, 1'b1, 1'b1, 40'h80000000, 1'b1, 1'b1);
        idle(); drain();

        // Backpressure with three beats in flight
        @(negedge clk);
        out_ready = 1'b0;
        send(0, 16'd7, 16'd8, 1'b0, 1'b0, 40'd56, 1'b0, 1'b0);
        send(0, 16'd9, 16'd10, 1'b0, 1'b0, 40'd90, 1'b0, 1'b0);
        send(0, 16'd11, 16'd12, 1'b0, 1'b0, 40'd132, 1'b0, 1'b0);
        idle();
        repeat (4) begin
            @(negedge clk);
            #1;
            check("stall_in_ready", 40'(in_ready), 40'(0));
            check("stall_out_valid", 40'(out_valid), 40'(1));
        end
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        // Reset with two beats in flight
        send(0, 16'd100, 16'd100, 1'b0, 1'b0, 40'd10000, 1'b0, 1'b0);
        send(0, 16'd200, 16'd200, 1'b0, 1'b0, 40'd40000, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        in_valid = 1'b0;
        q0.delete();
        #1;
        check("midrst_out_valid", 40'(out_valid), 40'(0));
        check("midrst_C", C, 40'(0));
        check("midrst_in_ready", 40'(in_ready), 40'(1));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1 check("no_stale", 40'(out_valid), 40'(0));
        end
        // Accumulate onto the cleared result register
        send(0, 16'd2, 16'd3, 1'b0, 1'b1, 40'd6, 1'b0, 1'b1);
        idle(); drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
